ctrl_msg_queue: RTL and testbench

Local I/O device that buffers zero-length control messages taken off the ring by the messenger. It sits directly downstream of the messenger's `ctrlValid`/`ctrlType`/`ctrlSrc` outputs. Each accepted event is queued as a {source, type} pair, and the CPU reads the queue through the standard AQ/RQ/WQ local I/O handshake. The CPU can mask out individual control types, and queue overflows are counted so that software can detect lost events.

---
 rtl/ctrl_msg_queue.sv | 135 +++++++++++++
 tb/tb_ctrl_msg_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_msg_queue.sv
// ctrl_msg_queue: buffers {source, type} control events arriving from the
// messenger and hands them to the CPU through the AQ/RQ/WQ local I/O handshake.
// Software can mask individual control types, and lost events are counted.
module ctrl_msg_queue #(
  parameter int DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:3]  aq,
  input  logic        read,
  input  logic [31:0] wq,
  output logic        rwq,
  output logic [31:0] rqCtrl,
  output logic        wrq,
  output logic        done,
  input  logic        selCtrl,
  input  logic        ctrlValid,
  input  logic [3:0]  ctrlType,
  input  logic [3:0]  ctrlSrc,
  output logic        ctrlPending
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    idle,
    rdResp,
    wrResp
  } stateT;

  stateT       state;
  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0] cnt;
  logic [7:0]  ovf;
  logic [15:0] mask;
  logic        wrqReg;
  logic        rwqReg;
  logic        doneReg;

  logic        popEn;
  logic        acceptEv;
  logic        pushEn;
  logic        dropEn;
  logic        clrOvf;
  logic        loadMask;
  logic [4:0]  cntM1;
  logic        unusedWq;

  // Upper write-queue bits carry no meaning for this device.
  assign unusedWq = ^wq[31:16];

  // Queue bookkeeping: a pop frees a slot that a same-cycle push may reuse,
  // and the mask register still holds its old value while a mask load is pending.
  always_comb begin
    popEn    = (state == rdResp) && (cnt != '0);
    acceptEv = ctrlValid && mask[ctrlType];
    pushEn   = acceptEv && ((cnt < FULL) || popEn);
    dropEn   = acceptEv && !pushEn;
    clrOvf   = (state == wrResp) && (aq == 2'd1);
    loadMask = (state == wrResp) && (aq == 2'd0);
  end

  // Response data is built from the current head, so an event enqueued one
  // cycle earlier is already visible here.
  always_comb begin
    rqCtrl = '0;
    cntM1  = 5'(cnt - (AW + 1)'(1));
    if ((state == rdResp) && !reset) begin
      if (cnt != '0) rqCtrl = {1'b1, 7'b0, ovf, 3'b0, cntM1, mem[rdPtr]};
      else           rqCtrl = {1'b0, 7'b0, ovf, 16'b0};
    end
  end

  // Handshake strobes are suppressed while reset is held so an aborted
  // response never signals completion.
  assign wrq         = wrqReg  && !reset;
  assign rwq         = rwqReg  && !reset;
  assign done        = doneReg && !reset;
  assign ctrlPending = (cnt != '0);

  // Entry storage; contents need no reset because cnt defines what is valid.
  always_ff @(posedge clock) begin
    if (pushEn) mem[wrPtr] <= {ctrlSrc, ctrlType};
  end

  // Pointers, occupancy, overflow counter, mask and the request FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= idle;
      wrPtr   <= '0;
      rdPtr   <= '0;
      cnt     <= '0;
      ovf     <= '0;
      mask    <= 16'hFFFF;
      wrqReg  <= 1'b0;
      rwqReg  <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + 1'b1;
      if (popEn)  rdPtr <= rdPtr + 1'b1;
      case ({pushEn, popEn})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (clrOvf)                          ovf <= '0;
      else if (dropEn && (ovf != 8'hFF))   ovf <= ovf + 8'd1;
      if (loadMask) mask <= wq[15:0];

      wrqReg  <= 1'b0;
      rwqReg  <= 1'b0;
      doneReg <= 1'b0;
      case (state)
        idle: begin
          if (selCtrl && read) begin
            state   <= rdResp;
            wrqReg  <= 1'b1;
            doneReg <= 1'b1;
          end else if (selCtrl) begin
            state   <= wrResp;
            rwqReg  <= 1'b1;
            doneReg <= 1'b1;
          end
        end
        rdResp:  state <= idle;
        wrResp:  state <= idle;
        default: state <= idle;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_msg_queue.sv
// Testbench for ctrl_msg_queue: table-driven vectors plus hand-written
// sequences, with a model queue of expected entries as the scoreboard.
module tb_ctrl_msg_queue;

  localparam int DEPTH = 16;

  typedef enum int {OP_PUSH, OP_READ, OP_WRITE} opT;

  typedef struct {
    opT          kind;
    logic [3:0]  src;
    logic [3:0]  typ;
    logic [1:0]  op;
    logic [31:0] data;
    logic        checkRq;
    logic [31:0] expRq;
    logic        expPending;
  } vecT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:3]  aq = '0;
  logic        read = 1'b0;
  logic [31:0] wq = '0;
  logic        rwq;
  logic [31:0] rqCtrl;
  logic        wrq;
  logic        done;
  logic        selCtrl = 1'b0;
  logic        ctrlValid = 1'b0;
  logic [3:0]  ctrlType = '0;
  logic [3:0]  ctrlSrc = '0;
  logic        ctrlPending;

  int checks = 0;
  int failures = 0;

  logic [7:0]  sbq[$];
  logic [15:0] mMask = 16'hFFFF;
  logic [7:0]  mOvf = '0;

  ctrl_msg_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .aq(aq), .read(read), .wq(wq), .rwq(rwq),
    .rqCtrl(rqCtrl), .wrq(wrq), .done(done), .selCtrl(selCtrl),
    .ctrlValid(ctrlValid), .ctrlType(ctrlType), .ctrlSrc(ctrlSrc),
    .ctrlPending(ctrlPending)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] modelRead();
    logic [4:0] c;
    if (sbq.size() == 0) return {1'b0, 7'b0, mOvf, 16'b0};
    c = 5'(sbq.size() - 1);
    return {1'b1, 7'b0, mOvf, 3'b0, c, sbq[0]};
  endfunction

  task automatic modelPush(input logic [3:0] src, input logic [3:0] typ);
    if (mMask[typ]) begin
      if (sbq.size() < DEPTH) sbq.push_back({src, typ});
      else if (mOvf != 8'hFF) mOvf++;
    end
  endtask

  // Starts and ends one cycle-aligned operation (just after a rising edge).
  task automatic applyStimulus(input opT kind, input logic [3:0] src, input logic [3:0] typ,
                               input logic [1:0] op, input logic [31:0] data,
                               input bit cPush, output logic [31:0] rqSeen);
    logic [31:0] exp;
    rqSeen = '0;
    case (kind)
      OP_PUSH: begin
        ctrlValid = 1'b1; ctrlSrc = src; ctrlType = typ;
        modelPush(src, typ);
        tick();
        ctrlValid = 1'b0;
        @(negedge clock);
        checkOutput("pushPending", 32'(ctrlPending), 32'(sbq.size() != 0));
        tick();
      end
      OP_READ: begin
        selCtrl = 1'b1; read = 1'b1;
        @(negedge clock);
        checkOutput("rdDoneEarly", 32'(done), 32'd0);
        tick();
        if (cPush) begin ctrlValid = 1'b1; ctrlSrc = src; ctrlType = typ; end
        @(negedge clock);
        exp = modelRead();
        checkOutput("rdWrq", 32'(wrq), 32'd1);
        checkOutput("rdDone", 32'(done), 32'd1);
        checkOutput("rdRwq", 32'(rwq), 32'd0);
        checkOutput("rdData", rqCtrl, exp);
        rqSeen = rqCtrl;
        if (sbq.size() != 0) void'(sbq.pop_front());
        if (cPush) modelPush(src, typ);
        tick();
        selCtrl = 1'b0; read = 1'b0; ctrlValid = 1'b0;
        @(negedge clock);
        checkOutput("rdDoneLate", 32'(done), 32'd0);
        checkOutput("rdPending", 32'(ctrlPending), 32'(sbq.size() != 0));
        tick();
      end
      default: begin
        selCtrl = 1'b1; read = 1'b0; aq = op; wq = data;
        @(negedge clock);
        checkOutput("wrDoneEarly", 32'(done), 32'd0);
        tick();
        if (cPush) begin ctrlValid = 1'b1; ctrlSrc = src; ctrlType = typ; end
        @(negedge clock);
        checkOutput("wrRwq", 32'(rwq), 32'd1);
        checkOutput("wrDone", 32'(done), 32'd1);
        checkOutput("wrWrq", 32'(wrq), 32'd0);
        checkOutput("wrRq", rqCtrl, 32'd0);
        if (cPush) modelPush(src, typ);
        if (op == 2'd0) mMask = data[15:0];
        if (op == 2'd1) mOvf = '0;
        tick();
        selCtrl = 1'b0; ctrlValid = 1'b0;
        @(negedge clock);
        checkOutput("wrDoneLate", 32'(done), 32'd0);
        tick();
      end
    endcase
  endtask

  vecT vecs[10];
  logic [31:0] seen;

  initial begin
    vecs[0] = '{OP_READ,  4'd0, 4'd0, 2'd0, 32'h0,      1'b1, 32'h0000_0000, 1'b0};
    vecs[1] = '{OP_PUSH,  4'd3, 4'd5, 2'd0, 32'h0,      1'b0, 32'h0,         1'b1};
    vecs[2] = '{OP_PUSH,  4'd4, 4'd1, 2'd0, 32'h0,      1'b0, 32'h0,         1'b1};
    vecs[3] = '{OP_READ,  4'd0, 4'd0, 2'd0, 32'h0,      1'b1, 32'h8000_0135, 1'b1};
    vecs[4] = '{OP_READ,  4'd0, 4'd0, 2'd0, 32'h0,      1'b1, 32'h8000_0041, 1'b0};
    vecs[5] = '{OP_WRITE, 4'd0, 4'd0, 2'd0, 32'hFFDF,   1'b0, 32'h0,         1'b0};
    vecs[6] = '{OP_PUSH,  4'd1, 4'd5, 2'd0, 32'h0,      1'b0, 32'h0,         1'b0};
    vecs[7] = '{OP_PUSH,  4'd2, 4'd2, 2'd0, 32'h0,      1'b0, 32'h0,         1'b1};
    vecs[8] = '{OP_READ,  4'd0, 4'd0, 2'd0, 32'h0,      1'b1, 32'h8000_0022, 1'b0};
    vecs[9] = '{OP_WRITE, 4'd0, 4'd0, 2'd0, 32'hFFFF,   1'b0, 32'h0,         1'b0};

    // Reset and idle outputs
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstWrq", 32'(wrq), 32'd0);
    checkOutput("rstRwq", 32'(rwq), 32'd0);
    checkOutput("rstRq", rqCtrl, 32'd0);
    checkOutput("rstPending", 32'(ctrlPending), 32'd0);
    tick();

    // Table-driven basic sequence
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].kind, vecs[i].src, vecs[i].typ, vecs[i].op, vecs[i].data, 1'b0, seen);
      if (vecs[i].checkRq) checkOutput($sformatf("vecRq%0d", i), seen, vecs[i].expRq);
      checkOutput($sformatf("vecPending%0d", i), 32'(ctrlPending), 32'(vecs[i].expPending));
    end

    // Mask write and event in the same cycle: old mask still accepts type 5
    applyStimulus(OP_WRITE, 4'd7, 4'd5, 2'd0, 32'hFFDF, 1'b1, seen);
    applyStimulus(OP_READ, 4'd0, 4'd0, 2'd0, 32'h0, 1'b0, seen);
    checkOutput("oldMaskEvent", seen, 32'h8000_0075);
    applyStimulus(OP_WRITE, 4'd0, 4'd0, 2'd0, 32'hFFFF, 1'b0, seen);

    // Overflow: DEPTH+3 events with no reads
    for (int i = 0; i < DEPTH + 3; i++)
      applyStimulus(OP_PUSH, 4'(i), 4'(i + 1), 2'd0, 32'h0, 1'b0, seen);
    applyStimulus(OP_READ, 4'd0, 4'd0, 2'd0, 32'h0, 1'b0, seen);
    checkOutput("ovfField", 32'(seen[23:16]), 32'h03);
    checkOutput("ovfCntField", 32'(seen[12:8]), 32'(DEPTH - 1));
    for (int i = 0; i < DEPTH - 1; i++)
      applyStimulus(OP_READ, 4'd0, 4'd0, 2'd0, 32'h0, 1'b0, seen);
    applyStimulus(OP_WRITE, 4'd0, 4'd0, 2'd1, 32'h0, 1'b0, seen);
    applyStimulus(OP_READ, 4'd0, 4'd0, 2'd0, 32'h0, 1'b0, seen);
    checkOutput("ovfCleared", seen, 32'h0);

    // Offset pointers, fill, then push and pop together while full
    for (int i = 0; i < 5; i++) begin
      applyStimulus(OP_PUSH, 4'(i + 9), 4'(i), 2'd0, 32'h0, 1'b0, seen);
      applyStimulus(OP_READ, 4'd0, 4'd0, 2'd0, 32'h0, 1'b0, seen);
    end
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(OP_PUSH, 4'(i * 3), 4'(15 - i), 2'd0, 32'h0, 1'b0, seen);
    applyStimulus(OP_READ, 4'hA, 4'hC, 2'd0, 32'h0, 1'b1, seen);
    checkOutput("fullPopCnt", 32'(seen[12:8]), 32'(DEPTH - 1));
    applyStimulus(OP_READ, 4'd0, 4'd0, 2'd0, 32'h0, 1'b0, seen);
    checkOutput("fullKeepCnt", 32'(seen[12:8]), 32'(DEPTH - 1));
    checkOutput("fullNoOvf", 32'(seen[23:16]), 32'h0);
    for (int i = 0; i < DEPTH - 1; i++)
      applyStimulus(OP_READ, 4'd0, 4'd0, 2'd0, 32'h0, 1'b0, seen);
    checkOutput("wrapLast", seen, 32'h8000_00AC);

    // Reset during rdResp with 4 entries queued
    for (int i = 0; i < 4; i++)
      applyStimulus(OP_PUSH, 4'(i), 4'(i + 2), 2'd0, 32'h0, 1'b0, seen);
    selCtrl = 1'b1; read = 1'b1;
    tick();
    reset = 1'b1;
    @(negedge clock);
    checkOutput("rstRespDone", 32'(done), 32'd0);
    checkOutput("rstRespWrq", 32'(wrq), 32'd0);
    tick();
    reset = 1'b0; selCtrl = 1'b0; read = 1'b0;
    sbq.delete(); mOvf = '0; mMask = 16'hFFFF;
    @(negedge clock);
    checkOutput("rstRespPending", 32'(ctrlPending), 32'd0);
    tick();
    applyStimulus(OP_READ, 4'd0, 4'd0, 2'd0, 32'h0, 1'b0, seen);
    checkOutput("rstRespRead", seen, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
